// File: rtl/filter_bank.sv
// Multi-channel moving-average filter with optional per-channel peak events.
// Optional peak detector and event FIFO built when FILTER_BANK_PEAK_EN is defined.
module filter_bank #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 14,
  parameter int LOG2_WIN  = 3,
  parameter int EVT_DEPTH = 4,
  localparam int OUT_W = DATA_W + LOG2_WIN,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [OUT_W-1:0]         threshold,
  output logic                     out_valid,
  output logic [NUM_CH*OUT_W-1:0]  out_data,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [CH_W-1:0]          evt_ch,
  output logic [OUT_W-1:0]         evt_peak,
  output logic                     evt_overflow
);

  localparam int WIN = 1 << LOG2_WIN;
  localparam logic [LOG2_WIN:0] FULL = (LOG2_WIN+1)'(WIN);
  localparam logic [LOG2_WIN:0] LAST = (LOG2_WIN+1)'(WIN - 1);

  logic [DATA_W-1:0]   hist [NUM_CH][WIN];
  logic [LOG2_WIN-1:0] wptr;
  logic [LOG2_WIN:0]   fill;
  logic [OUT_W-1:0]    sum  [NUM_CH];
  logic [OUT_W-1:0]    nsum [NUM_CH];
  logic [DATA_W-1:0]   x    [NUM_CH];

  // next window sum: add newest sample, retire the one WIN samples back
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      x[c]    = in_data[c*DATA_W +: DATA_W];
      nsum[c] = sum[c] + OUT_W'(x[c]) - OUT_W'(hist[c][wptr]);
    end
  end

  // history ring, running sums, fill counter and output register
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      wptr      <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum[c] <= '0;
        for (int w = 0; w < WIN; w++)
          hist[c][w] <= '0;
      end
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        wptr      <= wptr + 1'b1;
        out_valid <= (fill >= LAST);
        if (fill != FULL)
          fill <= fill + 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
          sum[c]        <= nsum[c];
          hist[c][wptr] <= x[c];
          if (fill >= LAST)
            out_data[c*OUT_W +: OUT_W] <= nsum[c];
        end
      end
    end
  end

`ifdef FILTER_BANK_PEAK_EN

  localparam int PW = (EVT_DEPTH > 1) ? $clog2(EVT_DEPTH) : 1;
  localparam int CW = $clog2(EVT_DEPTH) + 1;
  localparam int EW = CH_W + OUT_W;

  typedef enum logic {IDLE, ABOVE} state_t;

  state_t            st_q [NUM_CH];
  state_t            st_d [NUM_CH];
  logic [OUT_W-1:0]  mx_q [NUM_CH];
  logic [OUT_W-1:0]  mx_d [NUM_CH];
  logic [OUT_W-1:0]  osum [NUM_CH];
  logic [NUM_CH-1:0] raise;

  logic [NUM_CH-1:0] pend_q;
  logic [NUM_CH-1:0] pend_d;
  logic [OUT_W-1:0]  pend_pk [NUM_CH];
  logic [CH_W-1:0]   sel;
  logic              have;

  logic [EW-1:0]     mem [EVT_DEPTH];
  logic [PW-1:0]     rd;
  logic [PW-1:0]     wr;
  logic [CW-1:0]     cnt;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;
  logic              ovf;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(EVT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // per-channel pulse tracker: enter above threshold, report max on exit
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      st_d[c]  = st_q[c];
      mx_d[c]  = mx_q[c];
      raise[c] = 1'b0;
      osum[c]  = out_data[c*OUT_W +: OUT_W];
      if (out_valid) begin
        unique case (st_q[c])
          IDLE: begin
            if (osum[c] > threshold) begin
              st_d[c] = ABOVE;
              mx_d[c] = osum[c];
            end
          end
          ABOVE: begin
            if (osum[c] > threshold) begin
              if (osum[c] > mx_q[c])
                mx_d[c] = osum[c];
            end else begin
              st_d[c]  = IDLE;
              raise[c] = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // tracker state registers
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c] <= IDLE;
        mx_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        st_q[c] <= st_d[c];
        mx_q[c] <= mx_d[c];
      end
    end
  end

  // pick lowest pending channel and decide push / drop / pop
  always_comb begin
    sel = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (pend_q[c])
        sel = CH_W'(c);
    have = |pend_q;
    full = (cnt == CW'(EVT_DEPTH));
    pop  = evt_valid && evt_ready;
    push = have && (!full || pop);
    drop = have && full && !pop;
    pend_d = pend_q;
    if (push || drop)
      pend_d[sel] = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (raise[c] && !pend_q[c])
        pend_d[c] = 1'b1;
  end

  // pending flags, FIFO pointers and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      pend_q <= '0;
      rd     <= '0;
      wr     <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++)
        pend_pk[c] <= '0;
    end else begin
      pend_q <= pend_d;
      for (int c = 0; c < NUM_CH; c++)
        if (raise[c] && !pend_q[c])
          pend_pk[c] <= mx_q[c];
      if (drop || |(raise & pend_q))
        ovf <= 1'b1;
      if (push)
        wr <= nxt(wr);
      if (pop)
        rd <= nxt(rd);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // event storage
  always_ff @(posedge clk) begin
    if (push)
      mem[wr] <= {sel, pend_pk[sel]};
  end

  assign evt_valid    = (cnt != '0);
  assign {evt_ch, evt_peak} = evt_valid ? mem[rd] : '0;
  assign evt_overflow = ovf;

`else

  logic unused_peak;
  assign unused_peak  = ^{threshold, evt_ready};
  assign evt_valid    = 1'b0;
  assign evt_ch       = '0;
  assign evt_peak     = '0;
  assign evt_overflow = 1'b0;

`endif

endmodule

// File: tb/tb_filter_bank.sv
// Randomized bench for filter_bank against a sample-history reference model.
// Peak-event checks follow FILTER_BANK_PEAK_EN, matching the DUT build.
module tb_filter_bank;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 14;
  localparam int LOG2_WIN  = 3;
  localparam int EVT_DEPTH = 4;
  localparam int OUT_W     = DATA_W + LOG2_WIN;
  localparam int CH_W      = 2;
  localparam int WIN       = 1 << LOG2_WIN;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     clear;
  logic                     in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [OUT_W-1:0]         threshold;
  logic                     out_valid;
  logic [NUM_CH*OUT_W-1:0]  out_data;
  logic                     evt_valid;
  logic                     evt_ready;
  logic [CH_W-1:0]          evt_ch;
  logic [OUT_W-1:0]         evt_peak;
  logic                     evt_overflow;

  filter_bank #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W),
    .LOG2_WIN(LOG2_WIN), .EVT_DEPTH(EVT_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_data(in_data),
    .threshold(threshold),
    .out_valid(out_valid), .out_data(out_data),
    .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_ch(evt_ch), .evt_peak(evt_peak),
    .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference model state
  int smp [NUM_CH][$];
  int m_cnt;
  bit m_ov;
  int m_od [NUM_CH];
  bit above [NUM_CH];
  int mx [NUM_CH];
  bit pend [NUM_CH];
  int ppk [NUM_CH];
  int fq_ch [$];
  int fq_pk [$];
  bit m_ovf;

  task automatic model_clear();
    m_cnt = 0;
    m_ov  = 0;
    m_ovf = 0;
    fq_ch.delete();
    fq_pk.delete();
    for (int c = 0; c < NUM_CH; c++) begin
      smp[c].delete();
      m_od[c]  = 0;
      above[c] = 0;
      mx[c]    = 0;
      pend[c]  = 0;
      ppk[c]   = 0;
    end
  endtask

  task automatic model_step();
    bit pov;
    int pod [NUM_CH];
    bit rs [NUM_CH];
    int rpk [NUM_CH];
    bit oldp [NUM_CH];
    int thr;
    int s;
    int sel;
    bit pop;
    bit full;
    pov = m_ov;
    for (int c = 0; c < NUM_CH; c++) pod[c] = m_od[c];
    if (!reset || clear) begin
      model_clear();
      return;
    end
    m_ov = 0;
    if (in_valid) begin
      m_cnt++;
      for (int c = 0; c < NUM_CH; c++) begin
        smp[c].push_back(int'(in_data[c*DATA_W +: DATA_W]));
        if (smp[c].size() > WIN) void'(smp[c].pop_front());
        s = 0;
        foreach (smp[c][k]) s += smp[c][k];
        if (m_cnt >= WIN) m_od[c] = s;
      end
      m_ov = (m_cnt >= WIN);
    end
`ifdef FILTER_BANK_PEAK_EN
    thr = int'(threshold);
    for (int c = 0; c < NUM_CH; c++) begin
      rs[c]   = 0;
      rpk[c]  = 0;
      oldp[c] = pend[c];
      if (pov) begin
        if (!above[c]) begin
          if (pod[c] > thr) begin
            above[c] = 1;
            mx[c] = pod[c];
          end
        end else if (pod[c] > thr) begin
          if (pod[c] > mx[c]) mx[c] = pod[c];
        end else begin
          above[c] = 0;
          rs[c]  = 1;
          rpk[c] = mx[c];
        end
      end
    end
    full = (fq_ch.size() == EVT_DEPTH);
    pop  = (fq_ch.size() > 0) && evt_ready;
    if (pop) begin
      void'(fq_ch.pop_front());
      void'(fq_pk.pop_front());
    end
    sel = -1;
    for (int c = NUM_CH - 1; c >= 0; c--) if (oldp[c]) sel = c;
    if (sel >= 0) begin
      pend[sel] = 0;
      if (!full || pop) begin
        fq_ch.push_back(sel);
        fq_pk.push_back(ppk[sel]);
      end else begin
        m_ovf = 1;
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (rs[c]) begin
        if (oldp[c]) m_ovf = 1;
        else begin
          pend[c] = 1;
          ppk[c]  = rpk[c];
        end
      end
    end
`else
    thr = 0; s = 0; sel = 0; pop = 0; full = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      rs[c] = 0; rpk[c] = 0; oldp[c] = 0;
    end
`endif
  endtask

  task automatic compare();
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    for (int c = 0; c < NUM_CH; c++)
      chk($sformatf("sum%0d", c),
          64'(out_data[c*OUT_W +: OUT_W]), 64'(m_od[c]));
`ifdef FILTER_BANK_PEAK_EN
    chk("evt_valid", 64'(evt_valid), 64'(fq_ch.size() > 0));
    chk("evt_ch", 64'(evt_ch),
        64'(fq_ch.size() > 0 ? fq_ch[0] : 0));
    chk("evt_peak", 64'(evt_peak),
        64'(fq_pk.size() > 0 ? fq_pk[0] : 0));
    chk("evt_ovf", 64'(evt_overflow), 64'(m_ovf));
`else
    chk("evt_off", 64'({evt_valid, evt_ch, evt_peak, evt_overflow}), 64'(0));
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic set_all(input int v0, input int v1,
                         input int v2, input int v3);
    in_data[0*DATA_W +: DATA_W] = DATA_W'(v0);
    in_data[1*DATA_W +: DATA_W] = DATA_W'(v1);
    in_data[2*DATA_W +: DATA_W] = DATA_W'(v2);
    in_data[3*DATA_W +: DATA_W] = DATA_W'(v3);
  endtask

  int ev2_n;
  int ev2_pk;
  int rdy_pct;

  initial begin
    reset = 0; clear = 0; in_valid = 0; evt_ready = 0;
    in_data = '0; threshold = OUT_W'(1000);
    model_clear();
    repeat (3) cyc();
    reset = 1;
    cyc();

    // constant 100 on ch0: first result after the 8th sample
    in_valid = 1;
    set_all(100, 0, 0, 0);
    for (int i = 0; i < WIN; i++) begin
      cyc();
      if (i == WIN - 2) chk("pre_fill", 64'(out_valid), 64'(0));
    end
    chk("fill_ov", 64'(out_valid), 64'(1));
    chk("ch0_800", 64'(out_data[0 +: OUT_W]), 64'(800));
    repeat (3) cyc();
    chk("ch0_hold", 64'(out_data[0 +: OUT_W]), 64'(800));

    // step on ch1
    set_all(100, 16, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (i <= WIN)
        chk("ch1_ramp", 64'(out_data[OUT_W +: OUT_W]), 64'(16 * i));
    end
    chk("ch1_128", 64'(out_data[OUT_W +: OUT_W]), 64'(128));

    // idle input keeps everything
    in_valid = 0;
    repeat (3) cyc();
    chk("idle_ov", 64'(out_valid), 64'(0));

    // clear, then a single pulse on ch2
    clear = 1;
    cyc();
    clear = 0;
    threshold = OUT_W'(50);
    evt_ready = 1;
    in_valid = 1;
    ev2_n = 0;
    ev2_pk = 0;
    for (int i = 0; i < 24; i++) begin
      set_all(0, 0, (i < WIN) ? 15 : 0, 0);
      cyc();
      if (evt_valid && evt_ch == 2) begin
        ev2_n++;
        ev2_pk = int'(evt_peak);
      end
    end
`ifdef FILTER_BANK_PEAK_EN
    chk("ch2_evts", 64'(ev2_n), 64'(1));
    chk("ch2_peak", 64'(ev2_pk), 64'(120));
    chk("ch2_ovf", 64'(evt_overflow), 64'(0));
`else
    chk("no_evt", 64'(ev2_n), 64'(0));
`endif

    // randomized segments
    for (int seg = 0; seg < 4; seg++) begin
      threshold = OUT_W'($urandom_range(80, 250));
      rdy_pct = (seg == 1) ? 0 : 30 * seg;
      for (int i = 0; i < 600; i++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        for (int c = 0; c < NUM_CH; c++)
          in_data[c*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 60));
        evt_ready = ($urandom_range(0, 99) < rdy_pct);
        clear     = ($urandom_range(0, 299) == 0);
        reset     = ($urandom_range(0, 499) != 0);
        cyc();
      end
      reset = 1;
      clear = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
